// File: rtl/seg7_mux_driver.sv
// Multiplexed 7-segment driver: time-slices SEG_UNITS digits with per-frame brightness/blank.
// Optional hex glyph decoding is enabled by defining SEG7_MUX_HEX_DECODE_EN.
module seg7_mux_driver #(
    parameter int SEG_UNITS       = 8,
    parameter int PRESCALE_BITS   = 16,
    parameter int BRIGHT_BITS     = 4,
    parameter int INVERT_ANODES   = 1,
    parameter int INVERT_SEGMENTS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SEG_UNITS*8-1:0] word,
    input  logic                   load,
    input  logic [SEG_UNITS-1:0]   blank,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic [SEG_UNITS-1:0]   anode,
    output logic [7:0]             segment,
    output logic                   frame_start
);
    localparam int IDX_W = (SEG_UNITS > 1) ? $clog2(SEG_UNITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(SEG_UNITS - 1);
    localparam logic [SEG_UNITS-1:0] AN_OFF = (INVERT_ANODES != 0) ? '1 : '0;
    localparam logic [7:0] SEG_OFF = (INVERT_SEGMENTS != 0) ? 8'hFF : 8'h00;

    logic [PRESCALE_BITS-1:0]     cnt;
    logic [IDX_W-1:0]             idx;
    logic [SEG_UNITS-1:0][7:0]    pending, display;
    logic                         pending_valid, started;
    logic [BRIGHT_BITS-1:0]       frame_bright;
    logic [SEG_UNITS-1:0]         frame_blank;
    logic                         tick, boundary, duty, lit;
    logic [7:0]                   pat, digit_byte;
    logic [SEG_UNITS-1:0]         onehot;

    assign tick     = &cnt;
    assign boundary = tick && (idx == LAST);

`ifdef SEG7_MUX_HEX_DECODE_EN
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b0111111;
            4'h1: hex_glyph = 7'b0000110;
            4'h2: hex_glyph = 7'b1011011;
            4'h3: hex_glyph = 7'b1001111;
            4'h4: hex_glyph = 7'b1100110;
            4'h5: hex_glyph = 7'b1101101;
            4'h6: hex_glyph = 7'b1111101;
            4'h7: hex_glyph = 7'b0000111;
            4'h8: hex_glyph = 7'b1111111;
            4'h9: hex_glyph = 7'b1101111;
            4'hA: hex_glyph = 7'b1110111;
            4'hB: hex_glyph = 7'b1111100;
            4'hC: hex_glyph = 7'b0111001;
            4'hD: hex_glyph = 7'b1011110;
            4'hE: hex_glyph = 7'b1111001;
            default: hex_glyph = 7'b1110001;
        endcase
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (tick) idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    // A load landing on the boundary bypasses pending so it is never lost or delayed a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending       <= '0;
            pending_valid <= 1'b0;
            display       <= '0;
            frame_bright  <= '0;
            frame_blank   <= '1;
            started       <= 1'b0;
        end else if (boundary) begin
            if (load)               display <= word;
            else if (pending_valid) display <= pending;
            pending_valid <= 1'b0;
            frame_bright  <= brightness;
            frame_blank   <= blank;
            started       <= 1'b1;
        end else if (load) begin
            pending       <= word;
            pending_valid <= 1'b1;
        end
    end

    always_comb begin
        duty       = (&frame_bright) || (cnt[PRESCALE_BITS-1 -: BRIGHT_BITS] < frame_bright);
        lit        = ~frame_blank[idx] & duty;
        onehot     = lit ? (SEG_UNITS'(1) << idx) : '0;
        digit_byte = display[idx];
`ifdef SEG7_MUX_HEX_DECODE_EN
        pat = {digit_byte[7], hex_glyph(digit_byte[3:0])};
`else
        pat = digit_byte;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode       <= AN_OFF;
            segment     <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            anode       <= onehot ^ AN_OFF;
            segment     <= (lit ? pat : 8'h00) ^ SEG_OFF;
            frame_start <= started && (idx == '0) && (cnt == '0);
        end
    end
endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver (4 digits, 4-bit prescaler, 2-bit brightness, inverted pins).
// Position-based model predicts every output cycle; literal checks pin key moments.
module tb_seg7_mux_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] word;
    logic        load;
    logic [3:0]  blank;
    logic [1:0]  brightness;
    logic [3:0]  anode;
    logic [7:0]  segment;
    logic        frame_start;

    int n_chk = 0, n_pass = 0;
    int k = 0;

    logic [31:0] m_disp = '0, m_pend = '0;
    logic        m_pv = 1'b0, m_started = 1'b0;
    logic [1:0]  m_br = '0;
    logic [3:0]  m_bl = '1;
    logic [3:0]  e_an = 4'hF;
    logic [7:0]  e_seg = 8'hFF;
    logic        e_fs = 1'b0;

    logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_mux_driver #(.SEG_UNITS(4), .PRESCALE_BITS(4), .BRIGHT_BITS(2),
                      .INVERT_ANODES(1), .INVERT_SEGMENTS(1)) dut (
        .clk(clk), .reset(rst), .word(word), .load(load), .blank(blank),
        .brightness(brightness), .anode(anode), .segment(segment),
        .frame_start(frame_start));

    always #5 clk = ~clk;

    function automatic logic [7:0] pat_of(input logic [7:0] b);
`ifdef SEG7_MUX_HEX_DECODE_EN
        return {b[7], glyph_tbl[b[3:0]]};
`else
        return b;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s k=%0d got %h want %h", name, k, act, exp);
    endtask

    // Model: edge k shows the position p=k (cycles since reset) one clock late;
    // 16 clocks per digit slot, 64 per frame, contents latched at each 64th edge.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            k = 0; m_disp = '0; m_pend = '0; m_pv = 0; m_br = '0; m_bl = '1; m_started = 0;
            e_an = 4'hF; e_seg = 8'hFF; e_fs = 1'b0;
        end else begin
            int p, digit, phase;
            logic on;
            p = k; digit = (p / 16) % 4; phase = p % 16;
            on = !m_bl[digit] && (m_br == 2'd3 || (phase / 4) < int'(m_br));
            e_an  = on ? ~(4'b0001 << digit) : 4'hF;
            e_seg = on ? ~pat_of(m_disp[digit*8 +: 8]) : 8'hFF;
            e_fs  = m_started && (p % 64 == 0);
            k++;
            if (k % 64 == 0) begin
                if (load) m_disp = word;
                else if (m_pv) m_disp = m_pend;
                m_pv = 0; m_br = brightness; m_bl = blank; m_started = 1;
            end else if (load) begin
                m_pend = word; m_pv = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("anode", anode, e_an);
        check("segment", segment, e_seg);
        check("frame_start", frame_start, e_fs);
    end

    task automatic goto(input int K);
        int n = 0;
        while (k < K && n < 4000) begin @(negedge clk); n++; end
        if (k < K) check("goto_timeout", k, K);
    endtask

    task automatic lit_chk(input string name, input logic [3:0] an, input logic [7:0] sg);
        check({name, "_an"}, anode, an);
        check({name, "_seg"}, segment, sg);
    endtask

    initial begin
        rst = 1'b1; load = 0; word = '0; blank = 4'b0000; brightness = 2'd3;
        repeat (3) @(negedge clk);
        lit_chk("reset", 4'hF, 8'hFF);
        check("reset_fs", frame_start, 1'b0);
        rst = 1'b0;
        word = 32'h01020408; load = 1;
        goto(1); load = 0;
        goto(40);
        lit_chk("pre_frame", 4'hF, 8'hFF);
        goto(65);
`ifndef SEG7_MUX_HEX_DECODE_EN
        lit_chk("slot0", 4'b1110, 8'hF7);
`endif
        check("fs_first", frame_start, 1'b1);
        goto(66);
        check("fs_once", frame_start, 1'b0);
`ifndef SEG7_MUX_HEX_DECODE_EN
        goto(81);  lit_chk("slot1", 4'b1101, 8'hFB);
        goto(97);  lit_chk("slot2", 4'b1011, 8'hFD);
        goto(113); lit_chk("slot3", 4'b0111, 8'hFE);
`endif
        goto(100); brightness = 2'd1;
        goto(129); check("b1_ph0", anode, 4'b1110);
        goto(132); check("b1_ph3", anode, 4'b1110);
        goto(133); check("b1_ph4", anode, 4'b1111);
        goto(150); brightness = 2'd0;
        goto(193); check("b0_dark", anode, 4'hF);
        goto(200); brightness = 2'd3; blank = 4'b0100;
        goto(257);
`ifndef SEG7_MUX_HEX_DECODE_EN
        lit_chk("blk_d0", 4'b1110, 8'hF7);
`endif
        goto(270); word = 32'hAAAAAAAA; load = 1;
        goto(271); load = 0;
        goto(280); word = 32'h55555555; load = 1; blank = 4'b0000;
        goto(281); load = 0;
        goto(289); lit_chk("blk_d2", 4'hF, 8'hFF);
`ifndef SEG7_MUX_HEX_DECODE_EN
        goto(305); lit_chk("unchanged_d3", 4'b0111, 8'hFE);
        goto(321); lit_chk("last_wins_d0", 4'b1110, 8'hAA);
        goto(353); lit_chk("last_wins_d2", 4'b1011, 8'hAA);
`endif
        goto(383); word = 32'h11223344; load = 1;
        goto(384); load = 0;
        goto(385);
`ifndef SEG7_MUX_HEX_DECODE_EN
        lit_chk("bypass", 4'b1110, 8'hBB);
`endif
        check("bypass_fs", frame_start, 1'b1);
`ifndef SEG7_MUX_HEX_DECODE_EN
        goto(449); lit_chk("no_pending", 4'b1110, 8'hBB);
`endif
        goto(460); word = 32'hFFFFFFFF; load = 1;
        goto(461); load = 0;
        #2 rst = 1'b1;
        @(negedge clk);
        lit_chk("mid_reset", 4'hF, 8'hFF);
        check("mid_reset_fs", frame_start, 1'b0);
        @(negedge clk); rst = 1'b0;
        goto(65);
`ifdef SEG7_MUX_HEX_DECODE_EN
        lit_chk("discard", 4'b1110, 8'hC0);
`else
        lit_chk("discard", 4'b1110, 8'hFF);
`endif
        goto(70); word = 32'h0000008A; load = 1;
        goto(71); load = 0;
        goto(129);
`ifdef SEG7_MUX_HEX_DECODE_EN
        lit_chk("glyph_8A", 4'b1110, 8'h08);
`else
        lit_chk("raw_8A", 4'b1110, 8'h75);
`endif
        goto(140);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
